// File: rtl/prog_mem_loader.sv
// Program-memory boot loader: takes a framed byte stream (SYNC, CNT_LO, CNT_HI,
// CNT little-endian words) and writes the words to consecutive word addresses
// from 0. The core is held in reset until the whole image has been written.
module prog_mem_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          MAX_WORDS = 1024,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  typedef enum logic [2:0] {IDLE, CNT0, CNT1, LOAD, DONE, ERR} state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          lane_q, lane_d;
  logic [23:0]         word_q, word_d;     // bytes 0..2 of the word in flight
  logic                fin_q, fin_d;       // last word's write is on the bus
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                byte_ready_q, byte_ready_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;

  logic                accept;
  logic [15:0]         idx_ext;
  logic [15:0]         cnt_full;

  assign accept   = byte_valid && byte_ready_q;
  assign idx_ext  = 16'(idx_q);
  assign cnt_full = {byte_data, cnt_q[7:0]};

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    word_d      = word_q;
    fin_d       = fin_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        idx_d  = '0;
        lane_d = 2'd0;
        fin_d  = 1'b0;
        if (accept && byte_data == SYNC_BYTE) state_d = CNT0;
      end
      CNT0: begin
        if (accept) begin
          cnt_d[7:0] = byte_data;
          state_d    = CNT1;
        end
      end
      CNT1: begin
        if (accept) begin
          cnt_d = cnt_full;
          if (cnt_full == 16'd0)       state_d = DONE;
          else if (cnt_full > MAX_CNT) state_d = ERR;
          else                         state_d = LOAD;
        end
      end
      LOAD: begin
        // Once the final word's write is on the bus, any byte that happens to
        // be accepted in that cycle is not part of the frame and is dropped.
        if (fin_q) begin
          state_d = DONE;
        end else if (accept) begin
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: word_d[7:0]   = byte_data;
            2'd1: word_d[15:8]  = byte_data;
            2'd2: word_d[23:16] = byte_data;
            default: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = idx_q;
              mem_wdata_d = {byte_data, word_q};
              idx_d       = idx_q + 1'b1;
              fin_d       = (idx_ext == cnt_q - 16'd1);
            end
          endcase
        end
      end
      DONE: begin
        if (start) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      ERR: begin
        if (start) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so that they line up
    // with state_q and come out of reset at their inactive values.
    byte_ready_d = (state_d == IDLE) || (state_d == CNT0) ||
                   (state_d == CNT1) || (state_d == LOAD);
    core_rst_n_d = (state_d == DONE);
    load_done_d  = (state_d == DONE);
    load_err_d   = (state_d == ERR);
  end

  // State and output registers, async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      lane_q       <= 2'd0;
      word_q       <= '0;
      fin_q        <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      byte_ready_q <= 1'b0;
      core_rst_n_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      fin_q        <= fin_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      byte_ready_q <= byte_ready_d;
      core_rst_n_q <= core_rst_n_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: expected writes are queued as frames
// are driven and checked against every mem_we pulse.
module tb_prog_mem_loader;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst_n;
  logic              load_done;
  logic              load_err;

  prog_mem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n), .load_done(load_done), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;
  int rdy_drops = 0;
  logic [41:0] exp_q[$];   // {addr, data}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every write pulse against the oldest expected write
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_we", {22'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [41:0] e;
        e = exp_q.pop_front();
        chk("we_addr", {22'd0, mem_addr}, {22'd0, e[41:32]});
        chk("we_data", mem_wdata, e[31:0]);
      end
    end
  end

  // Drive one byte, optionally after a gap; returns at the negedge after the
  // consuming edge. Called at a negedge.
  task automatic send(input logic [7:0] b, input int gap);
    int t;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 50) begin
      rdy_drops++;
      @(negedge clk);
      t++;
    end
    if (t == 50) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int maxgap);
    foreach (f[i]) send(f[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_s1();
    exp_q.push_back({10'd0, 32'h00A0_0513});
    exp_q.push_back({10'd1, 32'h0000_006F});
  endtask

  logic [7:0] f1[$];
  logic [7:0] f2[$];
  logic [7:0] f3[$];
  logic [7:0] f4[$];
  logic [7:0] f6a[$];
  int w0;

  initial begin
    f1  = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    f2  = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    f3  = '{8'hA5, 8'h01, 8'h04};
    f4  = '{8'hA5, 8'h00, 8'h00};
    f6a = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0};

    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_core",  {31'd0, core_rst_n}, 32'd0);
    chk("rst_flags", {30'd0, load_done, load_err}, 32'd0);
    chk("rst_addr",  {22'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, byte_ready}, 32'd1);

    // 1: two-word image
    push_s1();
    w0 = we_cnt;
    send_frame(f1, 0);
    chk("s1_done_early", {31'd0, load_done}, 32'd0);
    @(negedge clk);
    chk("s1_done", {31'd0, load_done}, 32'd1);
    chk("s1_core", {31'd0, core_rst_n}, 32'd1);
    chk("s1_ready", {31'd0, byte_ready}, 32'd0);
    repeat (2) @(negedge clk);
    chk("s1_ready_hold", {31'd0, byte_ready}, 32'd0);
    chk("s1_we_cnt", we_cnt - w0, 32'd2);
    chk("s1_hold_addr", {22'd0, mem_addr}, 32'd1);
    chk("s1_hold_data", mem_wdata, 32'h0000_006F);
    pulse_start();
    chk("s1_rearm_ready", {31'd0, byte_ready}, 32'd1);
    chk("s1_rearm_flags", {30'd0, load_done, core_rst_n}, 32'd0);

    // 2: junk before sync, one word
    exp_q.push_back({10'd0, 32'hDEAD_BEEF});
    w0 = we_cnt;
    send_frame(f2, 0);
    @(negedge clk);
    chk("s2_done", {31'd0, load_done}, 32'd1);
    chk("s2_we_cnt", we_cnt - w0, 32'd1);
    pulse_start();

    // 3: oversize count
    w0 = we_cnt;
    send_frame(f3, 0);
    chk("s3_err", {31'd0, load_err}, 32'd1);
    chk("s3_core", {31'd0, core_rst_n}, 32'd0);
    chk("s3_ready", {31'd0, byte_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("s3_we_cnt", we_cnt - w0, 32'd0);
    pulse_start();
    chk("s3_err_clr", {31'd0, load_err}, 32'd0);
    chk("s3_ready_idle", {31'd0, byte_ready}, 32'd1);

    // 4: empty image
    w0 = we_cnt;
    send_frame(f4, 0);
    chk("s4_done", {31'd0, load_done}, 32'd1);
    repeat (2) @(negedge clk);
    chk("s4_we_cnt", we_cnt - w0, 32'd0);
    pulse_start();

    // 5: image 1 with random gaps
    push_s1();
    w0 = we_cnt;
    rdy_drops = 0;
    send_frame(f1, 3);
    chk("s5_ready_drops", rdy_drops, 32'd0);
    @(negedge clk);
    chk("s5_done", {31'd0, load_done}, 32'd1);
    chk("s5_we_cnt", we_cnt - w0, 32'd2);
    pulse_start();

    // 6: async reset mid-load, then full replay
    send_frame(f6a, 0);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("s6_rst_addr", {22'd0, mem_addr}, 32'd0);
    chk("s6_rst_wdata", mem_wdata, 32'd0);
    chk("s6_rst_flags", {29'd0, core_rst_n, load_done, load_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_s1();
    w0 = we_cnt;
    send_frame(f1, 0);
    @(negedge clk);
    chk("s6_done", {31'd0, load_done}, 32'd1);
    chk("s6_we_cnt", we_cnt - w0, 32'd2);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
